// File: rtl/decoder_seq_if.sv
// Select/enable bus for decoder_seq: 74x138-style enables, select, sweep controls
// and the registered active-low strobe outputs with sweep status.
interface decoder_seq_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
);
    localparam int NOUT = 1 << SEL_W;

    logic               g1;
    logic               g2a_n;
    logic               g2b_n;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               start;
    logic [DWELL_W-1:0] dwell;
    logic [NOUT-1:0]    y_n;
    logic               busy;
    logic               done;

    modport master (
        output g1, g2a_n, g2b_n, sel, mode, start, dwell,
        input  y_n, busy, done
    );

    modport slave (
        input  g1, g2a_n, g2b_n, sel, mode, start, dwell,
        output y_n, busy, done
    );
endinterface

// File: rtl/decoder_seq.sv
// Registered N-to-2^N active-low decoder with 74x138 enable gating and an optional
// strobe sweep sequencer, compiled in when DECODER_SEQ_SWEEP_EN is defined.
module decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_seq_if.slave  bus
);
    localparam int NOUT = 1 << SEL_W;

    function automatic logic [NOUT-1:0] strobe_n(input logic [SEL_W-1:0] i);
        strobe_n = ~({{(NOUT-1){1'b0}}, 1'b1} << i);
    endfunction

    logic            en;
    logic [NOUT-1:0] direct_y_n;
    logic [NOUT-1:0] y_n_q;
    logic            busy_q;
    logic            done_q;

    assign en         = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
    assign direct_y_n = en ? strobe_n(bus.sel) : '1;

`ifdef DECODER_SEQ_SWEEP_EN
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_m1, dwell_m1_nxt;
    logic [DWELL_W-1:0] start_m1;
    logic [NOUT-1:0]    y_n_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               go;
    logic               last;

    assign go       = bus.start & bus.mode & en;
    assign last     = (&idx) && (cnt == '0);
    // A zero dwell behaves as a dwell of one, so reload value is D-1 either way.
    assign start_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = SWEEP;
            SWEEP:   if (!en) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        dwell_m1_nxt = dwell_m1;
        y_n_nxt      = '1;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    dwell_m1_nxt = start_m1;
                    idx_nxt      = '0;
                    cnt_nxt      = start_m1;
                    y_n_nxt      = strobe_n('0);
                    busy_nxt     = 1'b1;
                end else begin
                    y_n_nxt = direct_y_n;
                end
            end
            SWEEP: begin
                // Loss of enable aborts silently: outputs released, no done pulse.
                if (en) begin
                    if (last) begin
                        done_nxt = 1'b1;
                    end else if (cnt != '0) begin
                        cnt_nxt  = cnt - DWELL_W'(1);
                        y_n_nxt  = strobe_n(idx);
                        busy_nxt = 1'b1;
                    end else begin
                        idx_nxt  = idx + SEL_W'(1);
                        cnt_nxt  = dwell_m1;
                        y_n_nxt  = strobe_n(idx + SEL_W'(1));
                        busy_nxt = 1'b1;
                    end
                end
            end
            DONE:    y_n_nxt = direct_y_n;
            default: y_n_nxt = '1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            cnt      <= '0;
            dwell_m1 <= '0;
            y_n_q    <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            dwell_m1 <= dwell_m1_nxt;
            y_n_q    <= y_n_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end
`else
    logic unused_sweep_inputs;
    assign unused_sweep_inputs = ^{bus.mode, bus.start, bus.dwell};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_n_q <= '1;
        else        y_n_q <= direct_y_n;
    end

    assign busy_q = 1'b0;
    assign done_q = 1'b0;
`endif

    assign bus.y_n  = y_n_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_decoder_seq.sv
// Directed self-checking bench for decoder_seq (SEL_W=3, DWELL_W=4); sweep
// scenarios are exercised when DECODER_SEQ_SWEEP_EN is defined.
module tb_decoder_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] strobe_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #5 clk = ~clk;

    decoder_seq_if #(.SEL_W(3), .DWELL_W(4)) bus ();

    decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.g1 = 1'b0; bus.g2a_n = 1'b1; bus.g2b_n = 1'b1;
        bus.sel = 3'd0; bus.mode = 1'b0; bus.start = 1'b0; bus.dwell = 4'd0;
        #22;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL reset_init: got {busy,done,y_n}=%b_%h expected 00_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        rst_n = 1'b1;
        bus.g1 = 1'b1; bus.g2a_n = 1'b0; bus.g2b_n = 1'b0; bus.sel = 3'd2;
        step;
        checks++;
        if (bus.y_n !== 8'hFB) begin
            errors++; $display("FAIL reset_release: got y_n=%h expected fb", bus.y_n);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL reset_async: got {busy,done,y_n}=%b_%h expected 00_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        checks++;
        if (bus.y_n !== 8'hFF) begin
            errors++; $display("FAIL reset_hold: got y_n=%h expected ff", bus.y_n);
        end
        rst_n = 1'b1;
        step;
        checks++;
        if (bus.y_n !== 8'hFB) begin
            errors++; $display("FAIL reset_recover: got y_n=%h expected fb", bus.y_n);
        end
    endtask

    task automatic test_direct;
        bus.mode = 1'b0; bus.start = 1'b0; bus.sel = 3'd5;
        #1;
        checks++;
        if (bus.y_n !== 8'hFB) begin
            errors++; $display("FAIL direct_latency: got y_n=%h before edge expected fb", bus.y_n);
        end
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hDF}) begin
            errors++; $display("FAIL direct_sel5: got {busy,done,y_n}=%b_%h expected 00_df", {bus.busy, bus.done}, bus.y_n);
        end
        bus.g2b_n = 1'b1;
        step;
        checks++;
        if (bus.y_n !== 8'hFF) begin
            errors++; $display("FAIL direct_g2b: got y_n=%h expected ff", bus.y_n);
        end
        bus.g2b_n = 1'b0; bus.g2a_n = 1'b1;
        step;
        checks++;
        if (bus.y_n !== 8'hFF) begin
            errors++; $display("FAIL direct_g2a: got y_n=%h expected ff", bus.y_n);
        end
        bus.g2a_n = 1'b0; bus.g1 = 1'b0;
        step;
        checks++;
        if (bus.y_n !== 8'hFF) begin
            errors++; $display("FAIL direct_g1: got y_n=%h expected ff", bus.y_n);
        end
        bus.g1 = 1'b1; bus.sel = 3'd0;
        step;
        checks++;
        if (bus.y_n !== 8'hFE) begin
            errors++; $display("FAIL direct_sel0: got y_n=%h expected fe", bus.y_n);
        end
        bus.sel = 3'd7;
        step;
        checks++;
        if (bus.y_n !== 8'h7F) begin
            errors++; $display("FAIL direct_sel7: got y_n=%h expected 7f", bus.y_n);
        end
    endtask

`ifdef DECODER_SEQ_SWEEP_EN
    task automatic test_sweep;
        bus.mode = 1'b1; bus.dwell = 4'd2; bus.sel = 3'd5; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if ({bus.busy, bus.done, bus.y_n} !== {2'b10, strobe_tab[i]}) begin
                    errors++; $display("FAIL sweep_step%0d_%0d: got {busy,done,y_n}=%b_%h expected 10_%h", i, j, {bus.busy, bus.done}, bus.y_n, strobe_tab[i]);
                end
                step;
            end
        end
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b01, 8'hFF}) begin
            errors++; $display("FAIL sweep_done: got {busy,done,y_n}=%b_%h expected 01_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL sweep_done_pulse: got {busy,done}=%b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_zero_dwell;
        bus.dwell = 4'd0; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.busy, bus.done, bus.y_n} !== {2'b10, strobe_tab[i]}) begin
                errors++; $display("FAIL zero_dwell_step%0d: got {busy,done,y_n}=%b_%h expected 10_%h", i, {bus.busy, bus.done}, bus.y_n, strobe_tab[i]);
            end
            step;
        end
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b01, 8'hFF}) begin
            errors++; $display("FAIL zero_dwell_done: got {busy,done,y_n}=%b_%h expected 01_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
    endtask

    task automatic drain_to_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL %s: got done=%b after %0d cycles expected 1", name, bus.done, n);
        end
        step;
    endtask

    task automatic test_back_to_back;
        bus.dwell = 4'd1; bus.sel = 3'd5; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL b2b_done: got done=%b expected 1", bus.done);
        end
        bus.start = 1'b1;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hDF}) begin
            errors++; $display("FAIL b2b_start_in_done: got {busy,done,y_n}=%b_%h expected 00_df", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b10, 8'hFE}) begin
            errors++; $display("FAIL b2b_restart: got {busy,done,y_n}=%b_%h expected 10_fe", {bus.busy, bus.done}, bus.y_n);
        end
        bus.start = 1'b0;
        drain_to_done("b2b_drain");
    endtask

    task automatic test_abort;
        bus.dwell = 4'd2; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step;
        checks++;
        if (bus.y_n !== 8'hFB) begin
            errors++; $display("FAIL abort_pre: got y_n=%h expected fb", bus.y_n);
        end
        bus.g1 = 1'b0;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL abort_release: got {busy,done,y_n}=%b_%h expected 00_ff", {bus.busy, bus.done}, bus.y_n);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++; $display("FAIL abort_no_done%0d: got {busy,done}=%b expected 00", i, {bus.busy, bus.done});
            end
        end
        bus.g1 = 1'b1; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b10, 8'hFE}) begin
            errors++; $display("FAIL abort_restart: got {busy,done,y_n}=%b_%h expected 10_fe", {bus.busy, bus.done}, bus.y_n);
        end
        drain_to_done("abort_drain");
    endtask

    task automatic test_ignored_start;
        bus.dwell = 4'd1; bus.sel = 3'd5; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.busy, bus.done, bus.y_n} !== {2'b10, strobe_tab[i]}) begin
                errors++; $display("FAIL ignore_busy_step%0d: got {busy,done,y_n}=%b_%h expected 10_%h", i, {bus.busy, bus.done}, bus.y_n, strobe_tab[i]);
            end
            if (i == 2) begin
                bus.start = 1'b1; bus.dwell = 4'd5; bus.sel = 3'd1; bus.mode = 1'b0;
            end else if (i == 3) begin
                bus.start = 1'b0; bus.mode = 1'b1;
            end
            step;
        end
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b01, 8'hFF}) begin
            errors++; $display("FAIL ignore_busy_done: got {busy,done,y_n}=%b_%h expected 01_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        bus.g1 = 1'b0; bus.start = 1'b1;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL ignore_en0: got {busy,done,y_n}=%b_%h expected 00_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL ignore_en0_hold: got busy=%b expected 0", bus.busy);
        end
        bus.start = 1'b0; bus.g1 = 1'b1;
    endtask

    task automatic test_reset_mid_sweep;
        bus.dwell = 4'd3; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        step;
        step;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hFF}) begin
            errors++; $display("FAIL reset_mid_sweep: got {busy,done,y_n}=%b_%h expected 00_ff", {bus.busy, bus.done}, bus.y_n);
        end
        step;
        rst_n = 1'b1; bus.sel = 3'd5;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hDF}) begin
            errors++; $display("FAIL reset_mid_sweep_idle: got {busy,done,y_n}=%b_%h expected 00_df", {bus.busy, bus.done}, bus.y_n);
        end
    endtask
`else
    task automatic test_ignored_start;
        bus.mode = 1'b1; bus.start = 1'b1; bus.dwell = 4'd2; bus.sel = 3'd3;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hF7}) begin
            errors++; $display("FAIL nosweep_start: got {busy,done,y_n}=%b_%h expected 00_f7", {bus.busy, bus.done}, bus.y_n);
        end
        bus.start = 1'b0;
        step;
        checks++;
        if ({bus.busy, bus.done, bus.y_n} !== {2'b00, 8'hF7}) begin
            errors++; $display("FAIL nosweep_hold: got {busy,done,y_n}=%b_%h expected 00_f7", {bus.busy, bus.done}, bus.y_n);
        end
        bus.sel = 3'd6;
        step;
        checks++;
        if (bus.y_n !== 8'hBF) begin
            errors++; $display("FAIL nosweep_sel6: got y_n=%h expected bf", bus.y_n);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_direct;
`ifdef DECODER_SEQ_SWEEP_EN
        test_sweep;
        test_zero_dwell;
        test_back_to_back;
        test_abort;
        test_ignored_start;
        test_reset_mid_sweep;
`else
        test_ignored_start;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
